// File: rtl/fp32_sqrt_pkg.sv
// fp32_sqrt_pkg: shared types and constants for the fp32 square-root front end and root stage
package fp32_sqrt_pkg;
    typedef enum logic [2:0] {
        CLS_NORM = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_ZERO = 3'd2,
        CLS_INF  = 3'd3,
        CLS_QNAN = 3'd4,
        CLS_SNAN = 3'd5
    } fp_cls_e;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP_PINF = 32'h7F800000;
    localparam int FP_BIAS = 127;
    typedef struct packed {
        logic [23:0] mant;
        logic [9:0]  exp;
        logic        odd;
        fp_cls_e     cls;
        logic        special;
        logic [31:0] spec_res;
    } prenorm_t;
    function automatic fp_cls_e fp_classify(input logic [31:0] a);
        return (a[30:23] == 8'hFF) ? ((a[22:0] == 23'd0) ? CLS_INF : a[22] ? CLS_QNAN : CLS_SNAN)
             : (a[30:23] == 8'h00) ? ((a[22:0] == 23'd0) ? CLS_ZERO : CLS_SUB)
             : CLS_NORM;
    endfunction
endpackage

// File: rtl/fp32_sqrt_prenorm_if.sv
// fp32_sqrt_prenorm_if: operand-in / prenormalized-out handshake bundle
interface fp32_sqrt_prenorm_if #(parameter int TAG_W = 4);
    import fp32_sqrt_pkg::*;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [23:0]      out_mant;
    logic [9:0]       out_exp;
    logic             out_odd;
    fp_cls_e          out_cls;
    logic             out_special;
    logic [31:0]      out_spec_res;
    logic [TAG_W-1:0] out_tag;
    modport slave (
        input  in_valid, in_a, in_tag, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_odd, out_cls, out_special, out_spec_res, out_tag
    );
    modport master (
        output in_valid, in_a, in_tag, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_odd, out_cls, out_special, out_spec_res, out_tag
    );
endinterface

// File: rtl/fp_lzc24.sv
// fp_lzc24: combinational 24-bit leading-zero counter, all-zero input yields 24
module fp_lzc24 (
    input  logic [23:0] d,
    output logic [4:0]  cnt
);
    always_comb begin
        cnt = 5'd24;
        for (int i = 0; i < 24; i++)
            if (d[i]) cnt = 5'(23 - i);
    end
endmodule

// File: rtl/fp32_sqrt_prenorm.sv
// fp32_sqrt_prenorm: two-stage classify/normalize front end feeding the fp32 root datapath
module fp32_sqrt_prenorm
    import fp32_sqrt_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input logic clk,
    input logic rst_n,
    fp32_sqrt_prenorm_if.slave io
);
    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_a_q, s1_a_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    fp_cls_e          s1_cls_q, s1_cls_d;
    logic [4:0]       s1_lz_q, s1_lz_d;
    logic             s2_valid_q, s2_valid_d;
    prenorm_t         s2_q, s2_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_load, s1_take;
    fp_cls_e          cls_in;
    logic [4:0]       lz_raw;
    logic [23:0]      mant_n;
    logic [9:0]       exp_n;
    logic             nan_n, spec_n;
    logic [31:0]      res_n;
    fp_lzc24 u_lzc (.d({1'b0, io.in_a[22:0]}), .cnt(lz_raw));
    assign cls_in      = fp_classify(io.in_a);
    assign s2_load     = !s2_valid_q || io.out_ready;
    assign io.in_ready = !s1_valid_q || s2_load;
    assign s1_take     = io.in_ready && io.in_valid;
    always_comb begin
        s1_valid_d = io.in_ready ? io.in_valid : s1_valid_q;
        s1_a_d     = s1_take ? io.in_a : s1_a_q;
        s1_tag_d   = s1_take ? io.in_tag : s1_tag_q;
        s1_cls_d   = s1_take ? cls_in : s1_cls_q;
        s1_lz_d    = s1_take ? ((cls_in == CLS_SUB) ? lz_raw : 5'd0) : s1_lz_q;
    end
    // Subnormal exponent is -126 minus the shift that brings the leading one to bit 23
    always_comb begin
        mant_n = (s1_cls_q == CLS_SUB)  ? 24'({1'b0, s1_a_q[22:0]} << s1_lz_q)
               : (s1_cls_q == CLS_ZERO) ? 24'd0
               : {1'b1, s1_a_q[22:0]};
        exp_n  = (s1_cls_q == CLS_NORM) ? {2'b00, s1_a_q[30:23]} - 10'(FP_BIAS)
               : (s1_cls_q == CLS_SUB)  ? 10'(-126) - {5'd0, s1_lz_q}
               : (s1_cls_q == CLS_ZERO) ? 10'(-127)
               : 10'd128;
        nan_n  = (s1_cls_q == CLS_QNAN) || (s1_cls_q == CLS_SNAN)
              || (s1_a_q[31] && (s1_cls_q != CLS_ZERO));
        spec_n = nan_n || (s1_cls_q == CLS_INF) || (s1_cls_q == CLS_ZERO);
        res_n  = nan_n ? FP_QNAN
               : (s1_cls_q == CLS_INF)  ? FP_PINF
               : (s1_cls_q == CLS_ZERO) ? s1_a_q
               : 32'd0;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_tag_d   = (s2_load && s1_valid_q) ? s1_tag_q : s2_tag_q;
        s2_d       = (s2_load && s1_valid_q)
                   ? prenorm_t'{mant: mant_n, exp: exp_n, odd: exp_n[0], cls: s1_cls_q,
                                special: spec_n, spec_res: res_n}
                   : s2_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_tag_q   <= '0;
            s1_cls_q   <= CLS_NORM;
            s1_lz_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_tag_q   <= s1_tag_d;
            s1_cls_q   <= s1_cls_d;
            s1_lz_q    <= s1_lz_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
            s2_tag_q   <= s2_tag_d;
        end
    end
    assign io.out_valid    = s2_valid_q;
    assign io.out_mant     = s2_q.mant;
    assign io.out_exp      = s2_q.exp;
    assign io.out_odd      = s2_q.odd;
    assign io.out_cls      = s2_q.cls;
    assign io.out_special  = s2_q.special;
    assign io.out_spec_res = s2_q.spec_res;
    assign io.out_tag      = s2_tag_q;
endmodule

// File: tb/tb_fp32_sqrt_prenorm.sv
// tb_fp32_sqrt_prenorm: directed vector table plus handshake, backpressure and reset sequences
module tb_fp32_sqrt_prenorm;
    import fp32_sqrt_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    fp32_sqrt_prenorm_if #(.TAG_W(4)) io ();
    fp32_sqrt_prenorm #(.TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .io(io.slave));
    typedef struct {
        logic [31:0] a;
        logic [3:0]  tag;
        logic [23:0] mant;
        logic [9:0]  ex;
        logic        odd;
        logic [2:0]  cls;
        logic        sp;
        logic [31:0] res;
    } rec_t;
    rec_t tv[16];
    rec_t got_q[$];
    rec_t snap;
    int n_vec = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n0;
    function automatic rec_t mk(logic [31:0] a, logic [3:0] t, logic [23:0] m, logic [9:0] e,
                                logic o, logic [2:0] c, logic s, logic [31:0] r);
        rec_t v;
        v.a = a; v.tag = t; v.mant = m; v.ex = e; v.odd = o; v.cls = c; v.sp = s; v.res = r;
        return v;
    endfunction
    function automatic rec_t cur();
        return mk(32'd0, io.out_tag, io.out_mant, io.out_exp, io.out_odd, 3'(io.out_cls),
                  io.out_special, io.out_spec_res);
    endfunction
    always @(negedge clk) begin
        if (rst_n && io.out_valid && io.out_ready) got_q.push_back(cur());
        if (rst_n && io.in_valid && io.in_ready) n_acc++;
    end
    task automatic check(input string nm, input rec_t g, input rec_t e);
        n_vec++;
        if ({g.tag, g.mant, g.ex, g.odd, g.cls, g.sp, g.res} !== {e.tag, e.mant, e.ex, e.odd, e.cls, e.sp, e.res}) begin
            n_bad++;
            $display("FAIL %s: got tag=%h mant=%h exp=%h odd=%b cls=%0d sp=%b res=%h, want tag=%h mant=%h exp=%h odd=%b cls=%0d sp=%b res=%h",
                     nm, g.tag, g.mant, g.ex, g.odd, g.cls, g.sp, g.res, e.tag, e.mant, e.ex, e.odd, e.cls, e.sp, e.res);
        end
    endtask
    task automatic check1(input string nm, input logic [63:0] g, input logic [63:0] e);
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, g, e);
        end
    endtask
    task automatic sync();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [31:0] a, input logic [3:0] t);
        int k = 0;
        io.in_valid = 1'b1;
        io.in_a = a;
        io.in_tag = t;
        @(negedge clk);
        while (!io.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!io.in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: tag %h never accepted", t);
        end
        @(posedge clk);
        #1 io.in_valid = 1'b0;
    endtask
    task automatic wait_out(input int n);
        int k = 0;
        while (got_q.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (got_q.size() < n) begin
            n_vec++;
            n_bad++;
            $display("FAIL out_timeout: got %0d outputs, want %0d", got_q.size(), n);
        end
    endtask
    task automatic pop_check(input string nm, input rec_t e);
        rec_t g;
        if (got_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no output, want tag=%h", nm, e.tag);
        end else begin
            g = got_q.pop_front();
            check(nm, g, e);
        end
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        tv[0]  = mk(32'h40800000, 0, 24'h800000, 10'h002, 0, 3'd0, 0, 32'h00000000);
        tv[1]  = mk(32'h00000001, 0, 24'h800000, 10'h36B, 1, 3'd1, 0, 32'h00000000);
        tv[2]  = mk(32'h00400000, 0, 24'h800000, 10'h381, 1, 3'd1, 0, 32'h00000000);
        tv[3]  = mk(32'h80000000, 0, 24'h000000, 10'h381, 1, 3'd2, 1, 32'h80000000);
        tv[4]  = mk(32'h00000000, 0, 24'h000000, 10'h381, 1, 3'd2, 1, 32'h00000000);
        tv[5]  = mk(32'hBF800000, 0, 24'h800000, 10'h000, 0, 3'd0, 1, 32'h7FC00000);
        tv[6]  = mk(32'h7F800000, 0, 24'h800000, 10'h080, 0, 3'd3, 1, 32'h7F800000);
        tv[7]  = mk(32'h7F800001, 0, 24'h800001, 10'h080, 0, 3'd5, 1, 32'h7FC00000);
        tv[8]  = mk(32'h7FC00000, 0, 24'hC00000, 10'h080, 0, 3'd4, 1, 32'h7FC00000);
        tv[9]  = mk(32'h3F800000, 0, 24'h800000, 10'h000, 0, 3'd0, 0, 32'h00000000);
        tv[10] = mk(32'h007FFFFF, 0, 24'hFFFFFE, 10'h381, 1, 3'd1, 0, 32'h00000000);
        tv[11] = mk(32'h7F7FFFFF, 0, 24'hFFFFFF, 10'h07F, 1, 3'd0, 0, 32'h00000000);
        tv[12] = mk(32'h00800000, 0, 24'h800000, 10'h382, 0, 3'd0, 0, 32'h00000000);
        tv[13] = mk(32'h00000002, 0, 24'h800000, 10'h36C, 0, 3'd1, 0, 32'h00000000);
        tv[14] = mk(32'h80000001, 0, 24'h800000, 10'h36B, 1, 3'd1, 1, 32'h7FC00000);
        tv[15] = mk(32'hFF800000, 0, 24'h800000, 10'h080, 0, 3'd3, 1, 32'h7FC00000);
        for (int i = 0; i < 16; i++) tv[i].tag = 4'(i);
        io.in_valid = 1'b0;
        io.in_a = '0;
        io.in_tag = '0;
        io.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_out_valid", 64'(io.out_valid), 64'd0);
        check1("rst_in_ready", 64'(io.in_ready), 64'd1);
        check("rst_outputs", cur(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        sync();
        rst_n = 1'b1;
        io.out_ready = 1'b1;
        drive(32'h40800000, 4'hA);
        @(negedge clk);
        check1("lat_cycle1_valid", 64'(io.out_valid), 64'd0);
        @(negedge clk);
        check1("lat_cycle2_valid", 64'(io.out_valid), 64'd1);
        wait_out(1);
        pop_check("four", mk(0, 4'hA, 24'h800000, 10'h002, 0, 3'd0, 0, 0));
        sync();
        got_q.delete();
        drive(32'hBF800000, 4'h1);
        drive(32'h7F800000, 4'h2);
        drive(32'h7F800001, 4'h3);
        wait_out(3);
        pop_check("b2b_neg", mk(0, 4'h1, 24'h800000, 10'h000, 0, 3'd0, 1, 32'h7FC00000));
        pop_check("b2b_inf", mk(0, 4'h2, 24'h800000, 10'h080, 0, 3'd3, 1, 32'h7F800000));
        pop_check("b2b_snan", mk(0, 4'h3, 24'h800001, 10'h080, 0, 3'd5, 1, 32'h7FC00000));
        sync();
        got_q.delete();
        for (int i = 0; i < 16; i++) drive(tv[i].a, tv[i].tag);
        wait_out(16);
        for (int i = 0; i < 16; i++) pop_check($sformatf("vec%0d_%h", i, tv[i].a), tv[i]);
        sync();
        got_q.delete();
        io.out_ready = 1'b0;
        n0 = n_acc;
        fork
            begin
                drive(32'h3F800000, 4'h4);
                drive(32'h40800000, 4'h5);
                drive(32'h00000001, 4'h6);
                drive(32'h7F800000, 4'h7);
            end
        join_none
        repeat (6) @(negedge clk);
        check1("bp_accepted", 64'(n_acc - n0), 64'd2);
        check1("bp_in_ready", 64'(io.in_ready), 64'd0);
        check1("bp_out_valid", 64'(io.out_valid), 64'd1);
        snap = cur();
        check("bp_head", snap, mk(0, 4'h4, 24'h800000, 10'h000, 0, 3'd0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), cur(), snap);
        end
        sync();
        io.out_ready = 1'b1;
        wait_out(4);
        repeat (5) @(negedge clk);
        check1("bp_out_count", 64'(got_q.size()), 64'd4);
        check1("bp_acc_total", 64'(n_acc - n0), 64'd4);
        pop_check("bp_0", mk(0, 4'h4, 24'h800000, 10'h000, 0, 3'd0, 0, 0));
        pop_check("bp_1", mk(0, 4'h5, 24'h800000, 10'h002, 0, 3'd0, 0, 0));
        pop_check("bp_2", mk(0, 4'h6, 24'h800000, 10'h36B, 1, 3'd1, 0, 0));
        pop_check("bp_3", mk(0, 4'h7, 24'h800000, 10'h080, 0, 3'd3, 1, 32'h7F800000));
        sync();
        got_q.delete();
        io.out_ready = 1'b0;
        drive(32'h40800000, 4'h8);
        drive(32'h00000001, 4'h9);
        #2 rst_n = 1'b0;
        #1;
        check1("arst_out_valid", 64'(io.out_valid), 64'd0);
        check1("arst_in_ready", 64'(io.in_ready), 64'd1);
        check("arst_outputs", cur(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        sync();
        rst_n = 1'b1;
        io.out_ready = 1'b1;
        got_q.delete();
        drive(32'h3F800000, 4'hB);
        @(negedge clk);
        check1("post_rst_lat1", 64'(io.out_valid), 64'd0);
        @(negedge clk);
        check1("post_rst_lat2", 64'(io.out_valid), 64'd1);
        wait_out(1);
        repeat (5) @(negedge clk);
        check1("post_rst_count", 64'(got_q.size()), 64'd1);
        pop_check("post_rst_op", mk(0, 4'hB, 24'h800000, 10'h000, 0, 3'd0, 0, 0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
